fmt_pkt_rx: RTL and testbench

FMT_PKT_RX -- requirements
Module: fmt_pkt_rx

---
 rtl/fmt_rx_pkg.sv | 30 +++
 rtl/fmt_rx_fifo.sv | 53 +++++
 rtl/fmt_pkt_rx.sv | 173 +++++++++++++++++
 tb/tb_fmt_pkt_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmt_rx_pkg.sv
// fmt_rx_pkg: shared types and constants for the formatter packet receiver
package fmt_rx_pkg;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;
    localparam int NUM_CH = 3;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_START,
        RECV,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [1:0]        chid;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // A packet is stored only if its channel exists and its length fits the buffer
    function automatic logic pkt_ok(input logic [1:0] chid, input logic [LEN_W-1:0] len, input int depth);
        return int'(chid) < NUM_CH && len != '0 && int'(len) <= depth;
    endfunction

endpackage

// File: rtl/fmt_rx_fifo.sv
// fmt_rx_fifo: synchronous first-word-fall-through FIFO with full/empty/count
module fmt_rx_fifo
    import fmt_rx_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = ENTRY_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty_o = r_count == '0;
    assign full_o  = r_count == (AW+1)'(DEPTH);
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rptr];
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);

    // Storage array, written at the tail; no reset needed since count gates reads
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= wdata_i;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                       (w_pop && !w_push) ? r_count - 1'b1 : r_count;
        end
    end

endmodule

// File: rtl/fmt_pkt_rx.sv
// fmt_pkt_rx: formatter packet receiver with reserved-space admission, FWFT output stream and sticky errors (per-channel packet counters only when FMT_RX_PKT_CNT_EN is defined)
module fmt_pkt_rx
    import fmt_rx_pkg::*;
#(
    parameter int FIFO_DEPTH    = 32,
    parameter int START_TIMEOUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fmt_req_i,
    input  logic [1:0]        fmt_chid_i,
    input  logic [LEN_W-1:0]  fmt_length_i,
    input  logic [DATA_W-1:0] fmt_data_i,
    input  logic              fmt_start_i,
    input  logic              fmt_end_i,
    output logic              fmt_grant_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_chid_o,
    output logic              out_sop_o,
    output logic              out_eop_o,
    output logic              err_len_o,
    output logic              err_proto_o,
    input  logic              err_clr_i,
    output logic [15:0]       ch0_pkt_cnt_o,
    output logic [15:0]       ch1_pkt_cnt_o,
    output logic [15:0]       ch2_pkt_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_chid;
    logic [LEN_W-1:0] r_len;
    logic             r_drop;
    logic             r_perr;
    logic [LEN_W:0]   r_wcnt;
    logic [LEN_W:0]   r_resv;
    logic [15:0]      r_tmo;
    logic             r_err_len;
    logic             r_err_proto;
    logic             w_grant;
    entry_t           w_wentry;
    entry_t           w_rentry;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic [31:0]      w_free;
    logic             w_fits;
    logic             w_req_ok;
    logic [LEN_W:0]   w_cnt_n;
    logic             w_at_len;
    logic             w_word;
    logic             w_wr;
    logic             w_eop;
    logic             w_len_bad;
    logic             w_tmo;
    logic             w_rstart;
    logic             w_set_proto;
    logic             w_pkt_good;

    // Free space excludes words already stored and words promised to the current packet
    assign w_free      = 32'(FIFO_DEPTH) - 32'(w_count) - 32'(r_resv);
    assign w_fits      = w_free >= 32'(fmt_length_i);
    assign w_req_ok    = pkt_ok(fmt_chid_i, fmt_length_i, FIFO_DEPTH);
    assign w_cnt_n     = r_wcnt + 1'b1;
    assign w_at_len    = w_cnt_n == {1'b0, r_len};
    assign w_word      = (r_state == WAIT_START && fmt_start_i) || r_state == RECV;
    assign w_wr        = w_word && !r_drop && !w_full;
    assign w_eop       = fmt_end_i || w_at_len;
    assign w_len_bad   = w_wr && (fmt_end_i ? !w_at_len : w_at_len);
    assign w_tmo       = r_state == WAIT_START && !fmt_start_i && r_tmo == 16'(START_TIMEOUT - 1);
    assign w_rstart    = r_state == RECV && fmt_start_i;
    assign w_set_proto = (r_state == IDLE && fmt_start_i) || w_rstart || (r_state == GRANT && r_drop) || w_tmo;
    assign w_pkt_good  = w_wr && w_eop && !w_len_bad && !r_perr && !w_rstart;
    assign w_wentry    = '{chid: r_chid, sop: r_state == WAIT_START, eop: w_eop, data: fmt_data_i};

    fmt_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_wr),
        .wdata_i(w_wentry),
        .pop_i  (out_vld_o && out_rdy_i),
        .rdata_o(w_rentry),
        .full_o (w_full),
        .empty_o(w_empty),
        .count_o(w_count)
    );

    assign out_vld_o   = !w_empty;
    assign out_data_o  = out_vld_o ? w_rentry.data : '0;
    assign out_chid_o  = out_vld_o ? w_rentry.chid : '0;
    assign out_sop_o   = out_vld_o && w_rentry.sop;
    assign out_eop_o   = out_vld_o && w_rentry.eop;
    assign fmt_grant_o = w_grant;
    assign err_len_o   = r_err_len;
    assign err_proto_o = r_err_proto;

    // Next-state and grant; invalid packets are granted without a space check and then discarded
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE:       w_next = (fmt_req_i && (!w_req_ok || w_fits)) ? GRANT : IDLE;
            GRANT: begin
                w_grant = 1'b1;
                w_next  = WAIT_START;
            end
            WAIT_START: w_next = fmt_start_i ? (fmt_end_i ? IDLE : (w_at_len && !r_drop) ? DRAIN : RECV) :
                                 w_tmo ? IDLE : WAIT_START;
            RECV:       w_next = fmt_end_i ? IDLE : (w_at_len && !r_drop) ? DRAIN : RECV;
            DRAIN:      w_next = fmt_end_i ? IDLE : DRAIN;
            default:    w_next = IDLE;
        endcase
    end

    // State register plus per-packet context, reservation and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_chid      <= '0;
            r_len       <= '0;
            r_drop      <= 1'b0;
            r_perr      <= 1'b0;
            r_wcnt      <= '0;
            r_resv      <= '0;
            r_tmo       <= '0;
            r_err_len   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && fmt_req_i) begin
                r_chid <= fmt_chid_i;
                r_len  <= fmt_length_i;
                r_drop <= !w_req_ok;
            end
            r_perr      <= (r_state == GRANT) ? 1'b0 : r_perr | w_len_bad | w_rstart;
            r_wcnt      <= (r_state == GRANT) ? '0 : w_word ? w_cnt_n : r_wcnt;
            r_tmo       <= (r_state == GRANT) ? '0 : (r_state == WAIT_START) ? r_tmo + 1'b1 : r_tmo;
            r_resv      <= (r_state == GRANT) ? (r_drop ? '0 : {1'b0, r_len}) :
                           (w_next == IDLE || w_next == DRAIN) ? '0 :
                           w_wr ? r_resv - 1'b1 : r_resv;
            r_err_len   <= w_len_bad | (r_err_len & ~err_clr_i);
            r_err_proto <= w_set_proto | (r_err_proto & ~err_clr_i);
        end
    end

`ifdef FMT_RX_PKT_CNT_EN
    logic [15:0] r_pkt_cnt [NUM_CH];

    // Count error-free packets per channel at their eop write, wrapping naturally
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i) r_pkt_cnt[c] <= '0;
            else if (w_pkt_good && r_chid == 2'(c)) r_pkt_cnt[c] <= r_pkt_cnt[c] + 16'd1;
        end
    end

    assign ch0_pkt_cnt_o = r_pkt_cnt[0];
    assign ch1_pkt_cnt_o = r_pkt_cnt[1];
    assign ch2_pkt_cnt_o = r_pkt_cnt[2];
`else
    assign ch0_pkt_cnt_o = 16'd0;
    assign ch1_pkt_cnt_o = 16'd0;
    assign ch2_pkt_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_fmt_pkt_rx.sv
// tb_fmt_pkt_rx: directed self-checking bench for fmt_pkt_rx
module tb_fmt_pkt_rx;

`ifdef FMT_RX_PKT_CNT_EN
    localparam logic [31:0] CE = 32'd1;
`else
    localparam logic [31:0] CE = 32'd0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fmt_req_i = 1'b0;
    logic [1:0]  fmt_chid_i = '0;
    logic [5:0]  fmt_length_i = '0;
    logic [31:0] fmt_data_i = '0;
    logic        fmt_start_i = 1'b0;
    logic        fmt_end_i = 1'b0;
    logic        fmt_grant_o;
    logic        out_vld_o;
    logic        out_rdy_i = 1'b0;
    logic [31:0] out_data_o;
    logic [1:0]  out_chid_o;
    logic        out_sop_o;
    logic        out_eop_o;
    logic        err_len_o;
    logic        err_proto_o;
    logic        err_clr_i = 1'b0;
    logic [15:0] ch0_pkt_cnt_o;
    logic [15:0] ch1_pkt_cnt_o;
    logic [15:0] ch2_pkt_cnt_o;
    int          n_chk = 0;
    int          n_fail = 0;

    fmt_pkt_rx dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fmt_req_i    (fmt_req_i),
        .fmt_chid_i   (fmt_chid_i),
        .fmt_length_i (fmt_length_i),
        .fmt_data_i   (fmt_data_i),
        .fmt_start_i  (fmt_start_i),
        .fmt_end_i    (fmt_end_i),
        .fmt_grant_o  (fmt_grant_o),
        .out_vld_o    (out_vld_o),
        .out_rdy_i    (out_rdy_i),
        .out_data_o   (out_data_o),
        .out_chid_o   (out_chid_o),
        .out_sop_o    (out_sop_o),
        .out_eop_o    (out_eop_o),
        .err_len_o    (err_len_o),
        .err_proto_o  (err_proto_o),
        .err_clr_i    (err_clr_i),
        .ch0_pkt_cnt_o(ch0_pkt_cnt_o),
        .ch1_pkt_cnt_o(ch1_pkt_cnt_o),
        .ch2_pkt_cnt_o(ch2_pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req_pkt(input logic [1:0] ch, input logic [5:0] len, input logic exp_grant);
        fmt_req_i    = 1'b1;
        fmt_chid_i   = ch;
        fmt_length_i = len;
        step();
        chk("grant", 32'(fmt_grant_o), 32'(exp_grant));
        fmt_req_i = 1'b0;
        step();
        chk("grant_one_cycle", 32'(fmt_grant_o), 32'd0);
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input int end_at);
        for (int i = 0; i < n; i++) begin
            fmt_start_i = (i == 0);
            fmt_end_i   = (i == end_at - 1);
            fmt_data_i  = base + 32'(i);
            step();
        end
        fmt_start_i = 1'b0;
        fmt_end_i   = 1'b0;
    endtask

    task automatic pop_chk(input logic [31:0] d, input logic s, input logic e, input logic [1:0] ch);
        chk("out_vld", 32'(out_vld_o), 32'd1);
        chk("out_data", out_data_o, d);
        chk("out_sop", 32'(out_sop_o), 32'(s));
        chk("out_eop", 32'(out_eop_o), 32'(e));
        chk("out_chid", 32'(out_chid_o), 32'(ch));
        out_rdy_i = 1'b1;
        step();
        out_rdy_i = 1'b0;
    endtask

    task automatic clr_err();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_vld", 32'(out_vld_o), 32'd0);
        chk("rst_grant", 32'(fmt_grant_o), 32'd0);
        chk("rst_err_len", 32'(err_len_o), 32'd0);
        chk("rst_err_proto", 32'(err_proto_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_cnt1", 32'(ch1_pkt_cnt_o), 32'd0);
        rst_i = 1'b0;
        step();

        // good packet on channel 1
        req_pkt(2'd1, 6'd4, 1'b1);
        send_words(4, 32'hA0, 4);
        chk("good_err_len", 32'(err_len_o), 32'd0);
        chk("good_err_proto", 32'(err_proto_o), 32'd0);
        for (int i = 0; i < 4; i++) pop_chk(32'hA0 + 32'(i), i == 0, i == 3, 2'd1);
        chk("good_empty", 32'(out_vld_o), 32'd0);
        chk("good_cnt1", 32'(ch1_pkt_cnt_o), CE);

        // short packet: end on word 5 of 8
        req_pkt(2'd2, 6'd8, 1'b1);
        send_words(5, 32'hB0, 5);
        chk("short_err_len", 32'(err_len_o), 32'd1);
        for (int i = 0; i < 5; i++) pop_chk(32'hB0 + 32'(i), i == 0, i == 4, 2'd2);
        chk("short_empty", 32'(out_vld_o), 32'd0);
        chk("short_cnt2", 32'(ch2_pkt_cnt_o), 32'd0);
        clr_err();
        chk("short_clr", 32'(err_len_o), 32'd0);

        // long packet: end on word 6 of 4
        req_pkt(2'd0, 6'd4, 1'b1);
        send_words(6, 32'hC0, 6);
        chk("long_err_len", 32'(err_len_o), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk(32'hC0 + 32'(i), i == 0, i == 3, 2'd0);
        chk("long_discard", 32'(out_vld_o), 32'd0);
        chk("long_cnt0", 32'(ch0_pkt_cnt_o), 32'd0);
        clr_err();

        // start timeout, then full-depth request proves the reservation was released
        req_pkt(2'd1, 6'd4, 1'b1);
        repeat (3) step();
        chk("tmo_not_yet", 32'(err_proto_o), 32'd0);
        step();
        chk("tmo_proto", 32'(err_proto_o), 32'd1);
        req_pkt(2'd0, 6'd32, 1'b1);
        repeat (4) step();
        clr_err();
        chk("tmo_clr", 32'(err_proto_o), 32'd0);

        // admission boundary with 30 of 32 words held
        req_pkt(2'd0, 6'd30, 1'b1);
        send_words(30, 32'h200, 30);
        chk("fill_err_len", 32'(err_len_o), 32'd0);
        req_pkt(2'd1, 6'd4, 1'b0);
        pop_chk(32'h200, 1'b1, 1'b0, 2'd0);
        req_pkt(2'd1, 6'd4, 1'b0);
        pop_chk(32'h201, 1'b0, 1'b0, 2'd0);
        req_pkt(2'd1, 6'd4, 1'b1);
        send_words(4, 32'h300, 4);
        for (int i = 2; i < 30; i++) pop_chk(32'h200 + 32'(i), 1'b0, i == 29, 2'd0);
        for (int i = 0; i < 4; i++) pop_chk(32'h300 + 32'(i), i == 0, i == 3, 2'd1);
        chk("fill_cnt0", 32'(ch0_pkt_cnt_o), CE);
        chk("fill_cnt1", 32'(ch1_pkt_cnt_o), CE * 2);

        // start in IDLE with clear in the same cycle: set wins
        fmt_start_i = 1'b1;
        err_clr_i   = 1'b1;
        step();
        chk("idle_start_set_wins", 32'(err_proto_o), 32'd1);
        fmt_start_i = 1'b0;
        step();
        err_clr_i = 1'b0;
        chk("idle_start_clr", 32'(err_proto_o), 32'd0);

        // invalid channel and zero length are granted but discarded
        req_pkt(2'd3, 6'd2, 1'b1);
        send_words(2, 32'hD0, 2);
        chk("ch3_discard", 32'(out_vld_o), 32'd0);
        chk("ch3_proto", 32'(err_proto_o), 32'd1);
        clr_err();
        req_pkt(2'd0, 6'd0, 1'b1);
        send_words(1, 32'hD8, 1);
        chk("len0_discard", 32'(out_vld_o), 32'd0);
        chk("len0_proto", 32'(err_proto_o), 32'd1);

        // reset in RECV after two words
        req_pkt(2'd1, 6'd4, 1'b1);
        send_words(2, 32'hE0, 0);
        chk("mid_vld", 32'(out_vld_o), 32'd1);
        rst_i = 1'b1;
        step();
        chk("mid_rst_vld", 32'(out_vld_o), 32'd0);
        chk("mid_rst_data", out_data_o, 32'd0);
        chk("mid_rst_proto", 32'(err_proto_o), 32'd0);
        chk("mid_rst_cnt0", 32'(ch0_pkt_cnt_o), 32'd0);
        chk("mid_rst_cnt1", 32'(ch1_pkt_cnt_o), 32'd0);
        rst_i = 1'b0;
        step();
        req_pkt(2'd1, 6'd4, 1'b1);
        send_words(4, 32'hF0, 4);
        for (int i = 0; i < 4; i++) pop_chk(32'hF0 + 32'(i), i == 0, i == 3, 2'd1);
        chk("post_rst_empty", 32'(out_vld_o), 32'd0);
        chk("post_rst_cnt1", 32'(ch1_pkt_cnt_o), CE);
        chk("post_rst_err_len", 32'(err_len_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
